// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU-sequenced multiplier.
// Holds the FSM state encoding, the ALU add control word and the iteration count.
package alu_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_DBL  = 2'd2,
        ST_DONE = 2'd3
    } mul_state_t;

    // Control bits in zx,nx,zy,ny,f,no order; f=1 alone selects x+y.
    localparam logic [5:0] ALU_CTL_ADD = 6'b000010;

    localparam int MUL_STEPS = 16;
    localparam logic [3:0] CNT_LAST = 4'(MUL_STEPS - 1);

endpackage

// File: rtl/alu_mul_seq_alu.sv
// Hack ALU: combinational 16-bit datapath selected by zx,nx,zy,ny,f,no.
// Zero latency, no flow control; zr/ng describe the unregistered result.
module alu_mul_seq_alu (
    input  logic [15:0] x,
    input  logic [15:0] y,
    input  logic        zx,
    input  logic        nx,
    input  logic        zy,
    input  logic        ny,
    input  logic        f,
    input  logic        no,
    output logic [15:0] out,
    output logic        zr,
    output logic        ng
);

    logic [15:0] x_z, x_n, y_z, y_n, f_out;

    always_comb begin
        x_z   = zx ? 16'h0000 : x;
        x_n   = nx ? ~x_z : x_z;
        y_z   = zy ? 16'h0000 : y;
        y_n   = ny ? ~y_z : y_z;
        f_out = f ? (x_n + y_n) : (x_n & y_n);
        out   = no ? ~f_out : f_out;
        zr    = (out == 16'h0000);
        ng    = out[15];
    end

endmodule

// File: rtl/alu_mul_seq.sv
// Shift-and-add 16x16->16 multiplier sequencing one Hack ALU; start accepted only in IDLE/DONE.
// Latency 32 edges from start to done, or 2*(msb index of b + 1) with MUL_EARLY_EXIT_EN defined.
module alu_mul_seq
    import alu_seq_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        busy,
    output logic        done,
    output logic [15:0] product,
    output logic        zr,
    output logic        ng
);

    mul_state_t  state;
    logic [15:0] acc;
    logic [15:0] mcand;
    logic [15:0] mplier;
    logic [3:0]  cnt;

    logic [15:0] alu_x;
    logic [15:0] alu_y;
    logic [5:0]  alu_ctl;
    logic [15:0] alu_out;
    logic        alu_zr_unused;
    logic        alu_ng_unused;
    logic        last_step;

    always_comb begin
        alu_ctl = ALU_CTL_ADD;
        alu_x   = 16'h0000;
        alu_y   = 16'h0000;
        case (state)
            ST_ADD: begin
                alu_x = acc;
                alu_y = mcand;
            end
            ST_DBL: begin
                alu_x = mcand;
                alu_y = mcand;
            end
            default: begin
                alu_x = 16'h0000;
                alu_y = 16'h0000;
            end
        endcase
    end

    // Early exit stops once no set multiplier bits remain above the one just consumed.
    always_comb begin
`ifdef MUL_EARLY_EXIT_EN
        last_step = (cnt == CNT_LAST) || (mplier[15:1] == 15'd0);
`else
        last_step = (cnt == CNT_LAST);
`endif
    end

    alu_mul_seq_alu u_alu (
        .x   (alu_x),
        .y   (alu_y),
        .zx  (alu_ctl[5]),
        .nx  (alu_ctl[4]),
        .zy  (alu_ctl[3]),
        .ny  (alu_ctl[2]),
        .f   (alu_ctl[1]),
        .no  (alu_ctl[0]),
        .out (alu_out),
        .zr  (alu_zr_unused),
        .ng  (alu_ng_unused)
    );

    // busy/done are registered alongside the state so they stay a pure decode of it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            acc     <= 16'h0000;
            mcand   <= 16'h0000;
            mplier  <= 16'h0000;
            cnt     <= 4'd0;
            product <= 16'h0000;
            zr      <= 1'b1;
            ng      <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        acc    <= 16'h0000;
                        mcand  <= a;
                        mplier <= b;
                        cnt    <= 4'd0;
                        state  <= ST_ADD;
                        busy   <= 1'b1;
                    end else begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                ST_ADD: begin
                    if (mplier[0]) begin
                        acc <= alu_out;
                    end
                    state <= ST_DBL;
                end
                ST_DBL: begin
                    mcand  <= alu_out;
                    mplier <= {1'b0, mplier[15:1]};
                    cnt    <= cnt + 4'd1;
                    if (last_step) begin
                        state   <= ST_DONE;
                        product <= acc;
                        zr      <= (acc == 16'h0000);
                        ng      <= acc[15];
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end else begin
                        state <= ST_ADD;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mul_seq.sv
// Directed-vector bench for alu_mul_seq; honours MUL_EARLY_EXIT_EN for expected latencies.
module tb_alu_mul_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [15:0] product;
    logic        zr;
    logic        ng;

    int n_checks = 0;
    int n_fail   = 0;

    alu_mul_seq dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product),
        .zr      (zr),
        .ng      (ng)
    );

    always #5 clk = ~clk;

`ifdef MUL_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive a start for one cycle; returns at the negedge just after the accepting edge.
    task automatic launch(input logic [15:0] av, input logic [15:0] bv);
        @(negedge clk);
        a     = av;
        b     = bv;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called at the negedge after the accepting edge; waits for done and checks it.
    task automatic wait_done(input string tag, input logic [15:0] ep, input int elat,
                             input bit inject, input bit chain,
                             input logic [15:0] na, input logic [15:0] nb);
        int edges = 0;
        int busyc = 0;
        if (inject) begin
            a = 16'h0009;
            b = 16'h0009;
        end
        while (!done && edges < 40) begin
            if (busy) busyc++;
            start = inject && (edges == 5 || edges == 10);
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        start = 1'b0;
        check({tag, " latency"}, edges, elat);
        check({tag, " busy_cycles"}, busyc, elat);
        check({tag, " busy_in_done"}, {31'd0, busy}, 32'd0);
        check({tag, " product"}, {16'd0, product}, {16'd0, ep});
        check({tag, " zr"}, {31'd0, zr}, {31'd0, (ep == 16'h0000)});
        check({tag, " ng"}, {31'd0, ng}, {31'd0, ep[15]});
        if (chain) begin
            a     = na;
            b     = nb;
            start = 1'b1;
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
            check({tag, " chain_busy"}, {31'd0, busy}, 32'd1);
            check({tag, " chain_done"}, {31'd0, done}, 32'd0);
        end else begin
            @(posedge clk);
            @(negedge clk);
            check({tag, " done_pulse_width"}, {31'd0, done}, 32'd0);
        end
    endtask

    initial begin
        int done_seen;
        reset = 1'b1;
        start = 1'b0;
        a     = 16'h0000;
        b     = 16'h0000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst busy", {31'd0, busy}, 32'd0);
        check("rst done", {31'd0, done}, 32'd0);
        check("rst product", {16'd0, product}, 32'd0);
        check("rst zr", {31'd0, zr}, 32'd1);
        check("rst ng", {31'd0, ng}, 32'd0);
        reset = 1'b0;

        launch(16'h0003, 16'h0005);
        check("3x5 busy_after_start", {31'd0, busy}, 32'd1);
        wait_done("3x5", 16'h000F, EARLY ? 6 : 32, 1'b0, 1'b0, 16'h0, 16'h0);

        launch(16'hFFFE, 16'h0007);
        wait_done("m2x7", 16'hFFF2, EARLY ? 6 : 32, 1'b0, 1'b0, 16'h0, 16'h0);

        launch(16'h0100, 16'h0100);
        wait_done("wrap", 16'h0000, EARLY ? 18 : 32, 1'b0, 1'b0, 16'h0, 16'h0);

        // Stray starts mid-flight, then a back-to-back start in the done cycle.
        launch(16'h0003, 16'h0005);
        wait_done("3x5 inj", 16'h000F, EARLY ? 6 : 32, 1'b1, 1'b1, 16'h0002, 16'h0002);
        wait_done("2x2 b2b", 16'h0004, EARLY ? 4 : 32, 1'b0, 1'b0, 16'h0, 16'h0);

        launch(16'h0007, 16'h0009);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("abort busy", {31'd0, busy}, 32'd0);
        check("abort done", {31'd0, done}, 32'd0);
        check("abort product", {16'd0, product}, 32'd0);
        check("abort zr", {31'd0, zr}, 32'd1);
        done_seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) done_seen++;
        end
        check("abort no_activity", done_seen, 0);

        launch(16'h0007, 16'h0009);
        wait_done("7x9", 16'h003F, EARLY ? 8 : 32, 1'b0, 1'b0, 16'h0, 16'h0);

        launch(16'h0001, 16'hFFFF);
        wait_done("1xFFFF", 16'hFFFF, 32, 1'b0, 1'b0, 16'h0, 16'h0);

        launch(16'h1234, 16'h0000);
        wait_done("bzero", 16'h0000, EARLY ? 2 : 32, 1'b0, 1'b0, 16'h0, 16'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
